// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and round-robin pick helper for rr_mux_arbiter
// Purpose: arbiter state enum and the rr_pick search. rr_pick is sized for up to
// MAX_N requesters. Callers zero-extend their request vector to MAX_N bits and
// pass mask = N-1, so the search wraps at the caller's real N.
package mux_arb_pkg;

  localparam int MAX_SEL = 5;
  localparam int MAX_N   = 1 << MAX_SEL;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Returns the index of the first set bit of req at or after ptr, wrapping mod (mask+1).
  // If no bit is set, ptr is returned; callers only use the result when |req.
  function automatic logic [MAX_SEL-1:0] rr_pick(
    input logic [MAX_N-1:0]   req,
    input logic [MAX_SEL-1:0] ptr,
    input logic [MAX_SEL-1:0] mask
  );
    logic [MAX_SEL-1:0] idx;
    logic [MAX_SEL-1:0] pick;
    logic               found;
    pick  = ptr & mask;
    found = 1'b0;
    for (int i = 0; i < MAX_N; i++) begin
      idx = (ptr + MAX_SEL'(i)) & mask;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/muxNto1.sv
// rtl/muxNto1.sv - N-to-1 data multiplexer, N = 2^SEL_WIDTH
// Ports:
//   in   N*w-bit concatenated inputs, slice k at [k*w +: w]
//   sel  SEL_WIDTH-bit slice index
//   out  w-bit selected slice
module muxNto1 #(
  parameter int SEL_WIDTH = 2,
  parameter int w         = 8
) (
  input  logic [(1<<SEL_WIDTH)*w-1:0] in,
  input  logic [SEL_WIDTH-1:0]        sel,
  output logic [w-1:0]                out
);

  assign out = in[sel*w +: w];

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin burst arbiter sharing one valid/ready data channel
// Purpose: grants one of N = 2^SEL_WIDTH requesters for a burst of req_len+1 beats.
// The granted requester's data is steered onto out_data by an internal muxNto1.
// Ports:
//   clk, rst_n  clock; asynchronous active-low reset
//   req         per-requester level request, held for the whole burst
//   req_len     per-requester beats-1, slice k at [k*LEN_W +: LEN_W]
//   req_data    per-requester current beat, slice k at [k*W +: W]
//   gnt, sel    registered one-hot grant and its index
//   beat_ack    one-hot pulse when the granted beat is consumed
//   out_valid, out_data, out_ready  output stream
//   busy        a burst is in progress
module rr_mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int SEL_WIDTH = 2,
  parameter int W         = 8,
  parameter int LEN_W     = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [(1<<SEL_WIDTH)-1:0]         req,
  input  logic [(1<<SEL_WIDTH)*LEN_W-1:0]   req_len,
  input  logic [(1<<SEL_WIDTH)*W-1:0]       req_data,
  output logic [(1<<SEL_WIDTH)-1:0]         gnt,
  output logic [(1<<SEL_WIDTH)-1:0]         beat_ack,
  output logic [SEL_WIDTH-1:0]              sel,
  output logic                              out_valid,
  output logic [W-1:0]                      out_data,
  input  logic                              out_ready,
  output logic                              busy
);

  localparam int N = 1 << SEL_WIDTH;

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [N-1:0]         gnt_q, gnt_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [SEL_WIDTH-1:0] pick;
  logic                 accept;

  assign pick = SEL_WIDTH'(rr_pick(MAX_N'(req), MAX_SEL'(ptr_q), MAX_SEL'(N - 1)));

  // A dropped request in BURST deasserts valid immediately, so an abort never acks.
  assign out_valid = (state_q == BURST) && req[sel_q];
  assign accept    = out_valid && out_ready;
  assign beat_ack  = gnt_q & {N{accept}};
  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign busy      = (state_q == BURST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BURST;
          sel_d   = pick;
          gnt_d   = N'(1) << pick;
          cnt_d   = req_len[pick*LEN_W +: LEN_W];
        end
      end
      BURST: begin
        // Abort and last beat both leave via IDLE, which guarantees one bubble between bursts.
        if (!req[sel_q] || (accept && (cnt_q == '0))) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + SEL_WIDTH'(1);
        end else if (accept) begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  muxNto1 #(
    .SEL_WIDTH(SEL_WIDTH),
    .w        (W)
  ) u_data_mux (
    .in (req_data),
    .sel(sel_q),
    .out(out_data)
  );

endmodule
